mcu_spi_select: RTL
===================

Name: mcu_spi_select

Overview:
- N-way selector for the MCU SPI control link. Routes one of NUM_SRC MCU ports (on-board BL616, M0S Dock, further carriers) onto the single mcu_* interface of misterynano.
- Default source is DEFAULT_SRC. Switches to another source once that source's chip-select is held low for a qualified time.
- Never switches mid-transaction. A partial first transaction is masked by a guard phase.
- Optionally reverts to the default source after an idle timeout. Instantiated in board toplevels in place of ad-hoc select logic.

Parameters:
NUM_SRC, 2, number of MCU SPI sources (2..8)
DEFAULT_SRC, 0, source selected after reset and on revert
SYNC_STAGES, 2, synchroniser flops on each src_csn for detection logic (>=2)
FILTER_LEN, 4, consecutive low samples of candidate csn required to qualify (1..255)
STICKY, 1, 1 = never revert; 0 = revert on idle timeout
IDLE_TIMEOUT, 32000000, clk32 cycles of active csn high before revert (STICKY=0 only; width = $clog2(IDLE_TIMEOUT+1))
BROADCAST, 1, 1 = src_oe all high; 0 = only the active source enabled

Ports:
clk32  in  1  32 MHz system clock
por_n  in  1  asynchronous active-low reset
src_sclk  in  NUM_SRC  SPI clock per source
src_csn  in  NUM_SRC  SPI chip-select per source, active low
src_mosi  in  NUM_SRC  MCU-to-FPGA data per source
src_oe  out  NUM_SRC  per-source output enable for miso/intn pads
mcu_miso  in  1  FPGA-to-MCU data from core
mcu_intn  in  1  interrupt from core, active low
src_miso  out  NUM_SRC  mcu_miso fanned out
src_intn  out  NUM_SRC  mcu_intn fanned out
mcu_sclk  out  1  selected SPI clock to core
mcu_csn  out  1  selected and gated chip-select to core
mcu_mosi  out  1  selected data to core
active_src  out  $clog2(NUM_SRC)  currently selected source index
guard  out  1  high while the new source's csn is masked
switch_pulse  out  1  one-cycle pulse on every change of active_src

Behaviour:
- Reset (por_n low, async), all state cleared:
  - active_src = DEFAULT_SRC; state = RUN; guard = 0; switch_pulse = 0.
  - Qualify counters and idle counter = 0; synchronisers = all ones.
  - mcu_csn forced 1 while por_n low.
- Data path is combinational from raw pins. No synchronisation on the SPI clock domain.
  - mcu_sclk = src_sclk[active_src]; mcu_mosi = src_mosi[active_src].
  - mcu_csn = guard | ~por_n | src_csn[active_src].
  - src_miso[i] = mcu_miso and src_intn[i] = mcu_intn for all i.
  - src_oe = all ones if BROADCAST, else one-hot(active_src).
- Detection uses the synchronised copy csn_s[i] (SYNC_STAGES flops).
- Qualification:
  - One counter per non-active source. Increments while csn_s[i] = 0 and saturates at FILTER_LEN.
  - Clears whenever csn_s[i] = 1, and for the active source.
  - Source i is qualified when its count = FILTER_LEN.
- State machine:
  - RUN:
    - If any source is qualified and csn_s[active_src] = 1: active_src <= lowest qualified index; switch_pulse = 1 for one cycle; guard <= 1; state <= GUARD.
    - If the active csn_s is low, the switch is deferred until it returns high. Qualification is held (saturated).
    - Revert (STICKY=0 and active_src != DEFAULT_SRC): idle counter counts cycles with csn_s[active_src] = 1 and clears on 0. When it reaches IDLE_TIMEOUT: active_src <= DEFAULT_SRC; switch_pulse; guard <= 1; state <= GUARD.
    - Revert loses to a pending qualification in the same cycle.
  - GUARD:
    - mcu_csn held 1. Leave to RUN when csn_s[active_src] has been 1 for 2 consecutive cycles; guard <= 0.
    - The interrupted first transaction is dropped and never reaches the core half-framed.
    - Qualification and revert are ignored in GUARD. Counters keep running.
- Switch latency: RUN, active idle. Candidate csn falls at cycle 0 → active_src changes at cycle SYNC_STAGES+FILTER_LEN (±1).
- Simultaneous qualification of several sources: lowest index wins. The others keep their saturated counts and win on a later idle window.
- A glitch on csn low shorter than FILTER_LEN samples: no switch, counter cleared.
- The idle counter resets on every switch. It never runs while active_src = DEFAULT_SRC.

Test Plan:
- Reset with NUM_SRC=2, DEFAULT_SRC=0 → active_src=0, mcu_csn=1 during reset, guard=0. After reset, src_csn[0]=0 → mcu_csn=0; toggling src_sclk[0] is seen on mcu_sclk.
- src_csn[1] low for 3 cycles, FILTER_LEN=4 → no switch, switch_pulse never asserted. Low for 10 cycles → active_src=1 at cycle 6±1, one switch_pulse, guard=1. Guard clears 2 cycles after src_csn[1] returns high (plus sync delay).
- src_csn[0] low (transaction running) while src_csn[1] is held low 20 cycles → active_src stays 0 until src_csn[0] rises, then switches within 1 cycle of the synchronised rise.
- NUM_SRC=4, src_csn[3] and src_csn[2] fall in the same cycle → active_src=2. After src_csn[2] goes idle, src_csn[3] still low → active_src=3.
- STICKY=0, IDLE_TIMEOUT=100, active_src=1, csn idle → revert to 0 after 100 cycles with switch_pulse. Source 1 busy every 50 cycles → no revert.
- por_n pulsed low during GUARD with active_src=2 → immediately active_src=DEFAULT_SRC, guard=0, mcu_csn=1. BROADCAST=0 → src_oe=4'b0001.

Source files
------------

// File: rtl/mcu_spi_select.sv
// Routes one of NUM_SRC MCU SPI ports onto the core's mcu_* link. Source changes
// happen only between transactions, and the new source's first partial frame is masked.
module mcu_spi_select #(
  parameter int NUM_SRC      = 2,
  parameter int DEFAULT_SRC  = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int STICKY       = 1,
  parameter int IDLE_TIMEOUT = 32000000,
  parameter int BROADCAST    = 1
) (
  input  logic                       clk32,
  input  logic                       por_n,
  input  logic [NUM_SRC-1:0]         src_sclk,
  input  logic [NUM_SRC-1:0]         src_csn,
  input  logic [NUM_SRC-1:0]         src_mosi,
  output logic [NUM_SRC-1:0]         src_oe,
  input  logic                       mcu_miso,
  input  logic                       mcu_intn,
  output logic [NUM_SRC-1:0]         src_miso,
  output logic [NUM_SRC-1:0]         src_intn,
  output logic                       mcu_sclk,
  output logic                       mcu_csn,
  output logic                       mcu_mosi,
  output logic [$clog2(NUM_SRC)-1:0] active_src,
  output logic                       guard,
  output logic                       switch_pulse,
  output logic                       state_dbg
);
  localparam int AW = $clog2(NUM_SRC);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW-1:0] DEF_IDX  = AW'(DEFAULT_SRC);
  localparam logic [CW-1:0] QUAL_MAX = CW'(FILTER_LEN);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  typedef enum logic {ST_RUN = 1'b0, ST_GUARD = 1'b1} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]      qual_cnt [NUM_SRC];
  logic [IW-1:0]      idle_cnt;
  logic               guard_hi;
  logic [NUM_SRC-1:0] csn_s;
  logic               active_hi;
  logic               any_qual;
  logic [AW-1:0]      win_idx;
  logic               revert_due;

  // Raw-pin data path; SPI signals never pass through clk32 flops.
  assign mcu_sclk  = src_sclk[active_src];
  assign mcu_mosi  = src_mosi[active_src];
  assign mcu_csn   = guard | ~por_n | src_csn[active_src];
  assign src_miso  = {NUM_SRC{mcu_miso}};
  assign src_intn  = {NUM_SRC{mcu_intn}};
  assign src_oe    = (BROADCAST != 0) ? {NUM_SRC{1'b1}} : (NUM_SRC'(1) << active_src);
  assign state_dbg = state;

  assign csn_s      = sync_q[SYNC_STAGES-1];
  assign active_hi  = csn_s[active_src];
  assign revert_due = (STICKY == 0) && (active_src != DEF_IDX) &&
                      (idle_cnt == IDLE_MAX) && active_hi;

  // Scanning downwards leaves the lowest qualified index as the winner.
  always_comb begin
    any_qual = 1'b0;
    win_idx  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (qual_cnt[i] == QUAL_MAX && AW'(i) != active_src) begin
        any_qual = 1'b1;
        win_idx  = AW'(i);
      end
    end
  end

  always_ff @(posedge clk32 or negedge por_n) begin
    if (!por_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
      for (int i = 0; i < NUM_SRC; i++) qual_cnt[i] <= '0;
      idle_cnt     <= '0;
      guard_hi     <= 1'b0;
      state        <= ST_RUN;
      active_src   <= DEF_IDX;
      guard        <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      sync_q[0] <= src_csn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];

      for (int i = 0; i < NUM_SRC; i++) begin
        if (csn_s[i] || AW'(i) == active_src) qual_cnt[i] <= '0;
        else if (qual_cnt[i] != QUAL_MAX)    qual_cnt[i] <= qual_cnt[i] + CW'(1);
      end

      if (STICKY == 0 && active_src != DEF_IDX && active_hi) begin
        if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IW'(1);
      end else begin
        idle_cnt <= '0;
      end

      switch_pulse <= 1'b0;
      case (state)
        ST_RUN: begin
          // A pending qualification takes priority over an idle revert.
          if ((any_qual && active_hi) || revert_due) begin
            active_src   <= any_qual ? win_idx : DEF_IDX;
            switch_pulse <= 1'b1;
            guard        <= 1'b1;
            guard_hi     <= 1'b0;
            idle_cnt     <= '0;
            state        <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (active_hi) begin
            if (guard_hi) begin
              guard <= 1'b0;
              state <= ST_RUN;
            end
            guard_hi <= 1'b1;
          end else begin
            guard_hi <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end
endmodule
